// File: rtl/befehls_holer.sv
// befehls_holer - instruction fetch unit.
// Reads instruction memory at the current PC over a request/ready interface,
// presents the returned word to the decoder with a valid/accept handshake and
// pulses PCWeiter once per accepted word to advance the program counter.
// Ports:
//   Clock, Reset            clock, synchronous active-high reset
//   AktuellerPC             current PC value
//   PCWeiter                one-cycle advance pulse to the PC
//   Anhalten                stall: no new fetch is started while high
//   Verwerfen               drop the current fetch and refetch from the PC
//   SpeicherAdresse/Lesen   registered read address and held read request
//   SpeicherDaten/Bereit    read data and its one-cycle valid strobe
//   Befehl/BefehlGueltig    fetched instruction and its valid flag
//   BefehlAngenommen        decoder accepts Befehl
//   Fehler                  sticky fetch-timeout fault
module befehls_holer #(
  parameter int ADRESS_BREITE = 26,
  parameter int DATEN_BREITE  = 32,
  parameter int WARTE_GRENZE  = 255
) (
  input  logic                     Clock,
  input  logic                     Reset,
  input  logic [ADRESS_BREITE-1:0] AktuellerPC,
  output logic                     PCWeiter,
  input  logic                     Anhalten,
  input  logic                     Verwerfen,
  output logic [ADRESS_BREITE-1:0] SpeicherAdresse,
  output logic                     SpeicherLesen,
  input  logic [DATEN_BREITE-1:0]  SpeicherDaten,
  input  logic                     SpeicherBereit,
  output logic [DATEN_BREITE-1:0]  Befehl,
  output logic                     BefehlGueltig,
  input  logic                     BefehlAngenommen,
  output logic                     Fehler
);

  typedef enum logic [2:0] {
    ADRESSE   = 3'd0,
    ANFRAGE   = 3'd1,
    AUSGABE   = 3'd2,
    WEITER    = 3'd3,
    VERWERFEN = 3'd4,
    FEHLER    = 3'd5
  } zustand_t;

  // Last counter value that may still wait; one more empty cycle is a fault.
  localparam logic [7:0] ZAEHLER_LETZT = 8'(WARTE_GRENZE - 1);

  zustand_t                 zustand_r, zustand_s;
  logic [7:0]               zaehler_r, zaehler_s;
  logic [ADRESS_BREITE-1:0] adresse_s;
  logic                     lesen_s;
  logic [DATEN_BREITE-1:0]  befehl_s;
  logic                     gueltig_s;
  logic                     weiter_s;
  logic                     fehler_s;

  // State register and all registered outputs.
  always_ff @(posedge Clock) begin
    if (Reset) begin
      zustand_r       <= ADRESSE;
      zaehler_r       <= 8'd0;
      SpeicherAdresse <= '0;
      SpeicherLesen   <= 1'b0;
      Befehl          <= '0;
      BefehlGueltig   <= 1'b0;
      PCWeiter        <= 1'b0;
      Fehler          <= 1'b0;
    end else begin
      zustand_r       <= zustand_s;
      zaehler_r       <= zaehler_s;
      SpeicherAdresse <= adresse_s;
      SpeicherLesen   <= lesen_s;
      Befehl          <= befehl_s;
      BefehlGueltig   <= gueltig_s;
      PCWeiter        <= weiter_s;
      Fehler          <= fehler_s;
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    zustand_s = zustand_r;
    zaehler_s = zaehler_r;
    adresse_s = SpeicherAdresse;
    lesen_s   = SpeicherLesen;
    befehl_s  = Befehl;
    gueltig_s = BefehlGueltig;
    weiter_s  = 1'b0;
    fehler_s  = Fehler;
    case (zustand_r)
      ADRESSE: begin
        if (!Anhalten) begin
          adresse_s = AktuellerPC;
          lesen_s   = 1'b1;
          zaehler_s = 8'd0;
          zustand_s = ANFRAGE;
        end else begin
          zustand_s = ADRESSE;
        end
      end
      // VERWERFEN waits exactly like ANFRAGE but never delivers its data.
      ANFRAGE, VERWERFEN: begin
        if (SpeicherBereit) begin
          lesen_s = 1'b0;
          if ((zustand_r == ANFRAGE) && !Verwerfen) begin
            befehl_s  = SpeicherDaten;
            gueltig_s = 1'b1;
            zustand_s = AUSGABE;
          end else begin
            zustand_s = ADRESSE;
          end
        end else if (zaehler_r == ZAEHLER_LETZT) begin
          lesen_s   = 1'b0;
          fehler_s  = 1'b1;
          zustand_s = FEHLER;
        end else begin
          zaehler_s = zaehler_r + 8'd1;
          if (Verwerfen) begin
            zustand_s = VERWERFEN;
          end else begin
            zustand_s = zustand_r;
          end
        end
      end
      // A discard wins over a simultaneous acceptance: no advance pulse.
      AUSGABE: begin
        if (Verwerfen) begin
          gueltig_s = 1'b0;
          zustand_s = ADRESSE;
        end else if (BefehlAngenommen) begin
          gueltig_s = 1'b0;
          weiter_s  = 1'b1;
          zustand_s = WEITER;
        end else begin
          zustand_s = AUSGABE;
        end
      end
      // The PC advances on the edge ending this state.
      WEITER: begin
        zustand_s = ADRESSE;
      end
      FEHLER: begin
        lesen_s   = 1'b0;
        gueltig_s = 1'b0;
        fehler_s  = 1'b1;
        zustand_s = FEHLER;
      end
      default: begin
        lesen_s   = 1'b0;
        gueltig_s = 1'b0;
        zustand_s = ADRESSE;
      end
    endcase
  end

endmodule
